// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared LSU data port (core m0, debug/DMA m1).
// Define MEM_ARB_FIXED_PRIO_EN to make m0 win every tie instead of round-robin.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int LOCK_MAX   = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_m0_req,
  input  logic              i_m0_wren,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic [3:0]        i_m0_bmask,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_wren,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic [3:0]        i_m1_bmask,
  input  logic              i_m1_lock,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [1:0] LAT_M1   = 2'(RD_LATENCY - 1);
  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_wait_cnt;
  logic [1:0]  w_wait_nxt;
  logic        r_last_owner;
  logic        r_rd_owner;
  logic [7:0]  r_lock_cnt;
  logic [7:0]  w_lock_nxt;

  logic        w_window;
  logic        w_rvalid;
  logic        w_g0;
  logic        w_g1;
  logic        w_gnt;
  logic        w_rd_gnt;
  logic        w_lock_path;
  logic        w_lock_full;
  logic        w_sel_wren;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [3:0]        w_sel_bmask;

  assign w_rvalid    = (r_state == S_WAIT) && (r_wait_cnt == 2'd0);
  assign w_window    = !i_reset &&
                       ((r_state == S_IDLE) || w_rvalid);
  assign w_lock_path = r_last_owner & i_m1_lock & i_m1_req;
  assign w_lock_full = (r_lock_cnt == LOCK_LIM);

  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (w_window) begin
      if (w_lock_path) begin
        // Starvation guard: one m0 grant after LOCK_MAX locked m1 grants
        if (w_lock_full && i_m0_req) w_g0 = 1'b1;
        else                         w_g1 = 1'b1;
      end else if (i_m0_req && i_m1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        w_g0 = 1'b1;
`else
        w_g0 = r_last_owner;
        w_g1 = !r_last_owner;
`endif
      end else begin
        w_g0 = i_m0_req;
        w_g1 = i_m1_req;
      end
    end
  end

  assign w_gnt       = w_g0 | w_g1;
  assign w_sel_wren  = w_g1 ? i_m1_wren  : i_m0_wren;
  assign w_sel_addr  = w_g1 ? i_m1_addr  : i_m0_addr;
  assign w_sel_wdata = w_g1 ? i_m1_wdata : i_m0_wdata;
  assign w_sel_bmask = w_g1 ? i_m1_bmask : i_m0_bmask;
  assign w_rd_gnt    = w_gnt & !w_sel_wren;

  assign o_m0_gnt    = w_g0;
  assign o_m1_gnt    = w_g1;
  assign o_mem_wren  = w_gnt & w_sel_wren;
  assign o_mem_addr  = w_gnt ? w_sel_addr : '0;
  assign o_mem_bmask = w_gnt ? w_sel_bmask : '0;
  assign o_mem_wdata = o_mem_wren ? w_sel_wdata : '0;

  assign o_m0_rvalid = w_rvalid & !r_rd_owner;
  assign o_m1_rvalid = w_rvalid & r_rd_owner;
  assign o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : '0;
  assign o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : '0;
  assign o_busy      = (r_state == S_WAIT);

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_rd_gnt) begin
          w_state_nxt = S_WAIT;
          w_wait_nxt  = LAT_M1;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt != 2'd0) begin
          w_wait_nxt = r_wait_cnt - 2'd1;
        end else if (w_rd_gnt) begin
          w_wait_nxt = LAT_M1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_wait_nxt  = 2'd0;
      end
    endcase
  end

  always_comb begin
    w_lock_nxt = r_lock_cnt;
    if (!i_m1_lock || w_g0)
      w_lock_nxt = 8'd0;
    else if (w_g1 && !w_lock_full)
      w_lock_nxt = r_lock_cnt + 8'd1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= 2'd0;
      r_last_owner <= 1'b1;
      r_rd_owner   <= 1'b0;
      r_lock_cnt   <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_lock_cnt <= w_lock_nxt;
      if (w_gnt)    r_last_owner <= w_g1;
      if (w_rd_gnt) r_rd_owner   <= w_g1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random and directed traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int LAT  = 2;
  localparam int LMAX = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_wren = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0;
  logic [3:0]  m0_bmask = 0;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req = 0, m1_wren = 0, m1_lock = 0;
  logic [31:0] m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m1_bmask = 0;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_bmask;
  logic        mem_wren, busy;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .RD_LATENCY(LAT), .LOCK_MAX(LMAX)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_req(m0_req), .i_m0_wren(m0_wren),
    .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .i_m0_bmask(m0_bmask), .o_m0_gnt(m0_gnt),
    .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
    .i_m1_req(m1_req), .i_m1_wren(m1_wren),
    .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .i_m1_bmask(m1_bmask), .i_m1_lock(m1_lock),
    .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid),
    .o_m1_rdata(m1_rdata),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_bmask(mem_bmask), .o_mem_wren(mem_wren),
    .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  typedef struct {
    int          cyc;
    int          who;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } gnt_t;

  typedef struct {
    int due;
    int who;
  } rd_t;

  gnt_t gnt_q[$];
  rd_t  rd_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit exp_busy = 0;

  // Model: who last owned the port, locked-grant run length, pending read
  int m_last = 1;
  int m_lock = 0;
  bit m_pend = 0;
  int m_due  = 0;

  bit in_lock = 0;
  int lock_run = 0;
  int lock_rec = -1;

  task automatic drive(input logic r, input logic q0, input logic w0,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic q1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1,
                       input logic lk);
    int who;
    bit win;
    logic sw;
    gnt_t g;
    rd_t  rr;
    @(negedge clk);
    cyc++;
    rst = r;
    m0_req = q0; m0_wren = w0; m0_addr = a0; m0_wdata = d0;
    m0_bmask = 4'($urandom);
    m1_req = q1; m1_wren = w1; m1_addr = a1; m1_wdata = d1;
    m1_bmask = 4'($urandom);
    m1_lock = lk;
    mem_rdata = $urandom;
    #1;
    who = -1;
    if (r) begin
      m_pend = 0; rd_q.delete();
      m_last = 1; m_lock = 0; exp_busy = 0;
    end else begin
      exp_busy = m_pend;
      win = !m_pend || (m_due == cyc);
      if (m_pend && m_due == cyc) m_pend = 0;
      if (win) begin
        if (m_last == 1 && lk && q1)
          who = (m_lock >= LMAX && q0) ? 0 : 1;
        else if (q0 && q1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
          who = 0;
`else
          who = (m_last == 0) ? 1 : 0;
`endif
        end else if (q0) who = 0;
        else if (q1) who = 1;
      end
      if (who >= 0) begin
        sw = (who == 1) ? w1 : w0;
        g.cyc = cyc; g.who = who; g.wren = sw;
        g.addr  = (who == 1) ? a1 : a0;
        g.wdata = sw ? ((who == 1) ? d1 : d0) : 32'd0;
        g.bmask = (who == 1) ? m1_bmask : m0_bmask;
        gnt_q.push_back(g);
        m_last = who;
        if (!sw) begin
          m_pend = 1; m_due = cyc + LAT;
          rr.due = m_due; rr.who = who;
          rd_q.push_back(rr);
        end
      end
      if (!lk || who == 0) m_lock = 0;
      else if (who == 1 && m_lock < LMAX) m_lock++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    gnt_t g;
    rd_t  rr;
    forever begin
      @(negedge clk);
      #2;
      if (in_lock) begin
        if (m1_gnt) lock_run++;
        if (m0_gnt && lock_rec < 0) lock_rec = lock_run;
      end
      checks++;
      if (m0_gnt || m1_gnt) begin
        if (gnt_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_gnt cyc=%0d got g0=%b g1=%b want none",
                   cyc, m0_gnt, m1_gnt);
        end else begin
          g = gnt_q.pop_front();
          if (m0_gnt && m1_gnt || g.cyc != cyc ||
              g.who != int'(m1_gnt) || g.wren != mem_wren ||
              g.addr != mem_addr || g.wdata != mem_wdata ||
              g.bmask != mem_bmask) begin
            errors++;
            $display("FAIL grant cyc=%0d got g0=%b g1=%b w=%b a=%h d=%h m=%h want cyc=%0d who=%0d w=%b a=%h d=%h m=%h",
                     cyc, m0_gnt, m1_gnt, mem_wren, mem_addr, mem_wdata,
                     mem_bmask, g.cyc, g.who, g.wren, g.addr, g.wdata,
                     g.bmask);
          end
        end
      end else begin
        if (mem_wren || mem_addr != 0 || mem_wdata != 0 ||
            mem_bmask != 0) begin
          errors++;
          $display("FAIL idle_bus cyc=%0d got w=%b a=%h d=%h m=%h want 0",
                   cyc, mem_wren, mem_addr, mem_wdata, mem_bmask);
        end
        if (gnt_q.size() > 0 && gnt_q[0].cyc <= cyc) begin
          g = gnt_q.pop_front();
          errors++;
          $display("FAIL missing_gnt cyc=%0d got none want who=%0d",
                   cyc, g.who);
        end
      end
      checks++;
      if (m0_rvalid || m1_rvalid) begin
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_rvalid cyc=%0d got v0=%b v1=%b want none",
                   cyc, m0_rvalid, m1_rvalid);
        end else begin
          rr = rd_q.pop_front();
          if (m0_rvalid && m1_rvalid || rr.due != cyc ||
              rr.who != int'(m1_rvalid) ||
              (m0_rvalid ? m0_rdata : m1_rdata) != mem_rdata ||
              (m0_rvalid ? m1_rdata : m0_rdata) != 0) begin
            errors++;
            $display("FAIL rvalid cyc=%0d got v0=%b v1=%b r0=%h r1=%h want due=%0d who=%0d data=%h",
                     cyc, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
                     rr.due, rr.who, mem_rdata);
          end
        end
      end else begin
        if (m0_rdata != 0 || m1_rdata != 0) begin
          errors++;
          $display("FAIL idle_rdata cyc=%0d got r0=%h r1=%h want 0",
                   cyc, m0_rdata, m1_rdata);
        end
        if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
          rr = rd_q.pop_front();
          errors++;
          $display("FAIL missing_rvalid cyc=%0d got none want who=%0d",
                   cyc, rr.who);
        end
      end
      checks++;
      if (busy != exp_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, exp_busy);
      end
    end
  end

  initial begin : stim
    drive(1, 1, 1, 32'h10, 32'h1, 1, 1, 32'h20, 32'h2, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // single store, m1 idle
    drive(0, 1, 1, 32'h7000, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    idle(1);
    // single load, observe latency and busy window
    drive(0, 1, 0, 32'h7004, 0, 0, 0, 0, 0, 0);
    idle(4);
    // tie on stores every cycle
    for (int i = 0; i < 6; i++)
      drive(0, 1, 1, 32'h100 + i, $urandom, 1, 1, 32'h200 + i, $urandom, 0);
    idle(1);
    // locked m1 burst with m0 held: starvation guard
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_lock = 1;
    for (int i = 0; i < 20; i++)
      drive(0, 1, 1, 32'h300, $urandom, 1, 1, 32'h400 + i, $urandom, 1);
    in_lock = 0;
    checks++;
    if (lock_rec != LMAX) begin
      errors++;
      $display("FAIL lock_guard got %0d m1 grants before m0 want %0d",
               lock_rec, LMAX);
    end
    idle(2);
    // load then reset before data returns
    drive(0, 0, 0, 0, 0, 1, 0, 32'h500, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 32'h600, $urandom, 1, 1, 32'h604, $urandom, 0);
    idle(2);
    // load in flight, both request stores
    drive(0, 1, 0, 32'h700, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      drive(0, 1, 1, 32'h710, $urandom, 1, 1, 32'h720, $urandom, 0);
    // back-to-back loads
    for (int i = 0; i < 4; i++)
      drive(0, 1, 0, 32'h800 + i, 0, 1, 0, 32'h900 + i, 0, 0);
    idle(4);
    // random traffic
    for (int i = 0; i < 3000; i++)
      drive(($urandom_range(0, 99) == 0),
            1'($urandom), 1'($urandom), $urandom, $urandom,
            1'($urandom), 1'($urandom), $urandom, $urandom,
            ($urandom_range(0, 3) != 0));
    idle(LAT + 3);
    checks++;
    if (gnt_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL drain got gq=%0d rq=%0d want 0 0",
               gnt_q.size(), rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
